// File: rtl/alct_lfsr_checker_pkg.sv
// Shared constants, state encoding and LFSR step for the ALCT pseudo-random
// pattern generator and its receive-side checker.
package alct_lfsr_checker_pkg;

   localparam int LFSR_LENGTH = 49;
   localparam logic [LFSR_LENGTH-1:0] SEED = 49'h123456789ABCD;

   typedef enum logic {
      ACQUIRE = 1'b0,
      LOCKED  = 1'b1
   } chk_state_t;

   // Taps are only valid for the 49-bit series; the generator calls this too.
   function automatic logic [LFSR_LENGTH-1:0] lfsr_next(input logic [LFSR_LENGTH-1:0] x);
      return {x[47:0], ~(x[48] ^ x[39])};
   endfunction

endpackage

// File: rtl/alct_popcount49.sv
// Combinational one-count of a 49-bit word: seven 7-bit groups, pairwise sums,
// then a final sum (three adder levels).
module alct_popcount49 (
   input  logic [48:0] data,
   output logic [5:0]  count
);

   logic [2:0] lvl1 [7];
   logic [3:0] lvl2 [4];

   // NOTE: combinational blocks use blocking '=' so later statements see the
   // freshly computed partial sums; every output is assigned on every pass.
   always_comb begin
      for (int g = 0; g < 7; g++) begin
         lvl1[g] = '0;
         for (int b = 0; b < 7; b++) begin
            lvl1[g] = lvl1[g] + 3'(data[7*g+b]);
         end
      end
      lvl2[0] = 4'(lvl1[0]) + 4'(lvl1[1]);
      lvl2[1] = 4'(lvl1[2]) + 4'(lvl1[3]);
      lvl2[2] = 4'(lvl1[4]) + 4'(lvl1[5]);
      lvl2[3] = 4'(lvl1[6]);
      count   = 6'(lvl2[0]) + 6'(lvl2[1]) + 6'(lvl2[2]) + 6'(lvl2[3]);
   end

endmodule

// File: rtl/alct_lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to the incoming 49-bit LFSR
// series and counts word and bit errors while locked.
module alct_lfsr_checker
   import alct_lfsr_checker_pkg::*;
#(
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 8,
   parameter int RUN_W        = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ce,
   input  logic [LFSR_LENGTH-1:0] rx_data,
   input  logic                   clear_cnt,
   output logic                   lock,
   output logic                   err,
   output logic [31:0]            word_cnt,
   output logic [15:0]            err_word_cnt,
   output logic [23:0]            err_bit_cnt,
   output logic [LFSR_LENGTH-1:0] expect_word
);

   chk_state_t             state_q, state_d;
   logic [RUN_W-1:0]       good_run_q, good_run_d, good_run_inc;
   logic [RUN_W-1:0]       bad_run_q, bad_run_d, bad_run_inc;
   logic [LFSR_LENGTH-1:0] expect_d;
   logic                   lock_d, err_d;
   logic [31:0]            word_cnt_d;
   logic [15:0]            err_word_cnt_d;
   logic [23:0]            err_bit_cnt_d;
   logic [24:0]            bit_sum;
   logic [5:0]             bit_errs;
   logic                   match, count_word, count_err;

   alct_popcount49 u_popcount (
      .data  (rx_data ^ expect_word),
      .count (bit_errs)
   );

   assign match        = (rx_data == expect_word);
   assign good_run_inc = good_run_q + 1'b1;
   assign bad_run_inc  = bad_run_q + 1'b1;
   assign bit_sum      = {1'b0, err_bit_cnt} + 25'(bit_errs);

   // NOTE: every signal gets a hold/default value first so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      expect_d   = expect_word;
      good_run_d = good_run_q;
      bad_run_d  = bad_run_q;
      lock_d     = lock;
      err_d      = 1'b0;
      count_word = 1'b0;
      count_err  = 1'b0;

      if (ce) begin
         case (state_q)
            ACQUIRE: begin
               if (match) begin
                  expect_d   = lfsr_next(expect_word);
                  good_run_d = good_run_inc;
                  if (good_run_inc == RUN_W'(LOCK_COUNT)) begin
                     state_d   = LOCKED;
                     lock_d    = 1'b1;
                     bad_run_d = '0;
                  end
               end else begin
                  expect_d   = lfsr_next(rx_data);
                  good_run_d = '0;
               end
            end
            LOCKED: begin
               // Free-running while locked so a corrupted word cannot shift alignment.
               expect_d   = lfsr_next(expect_word);
               count_word = 1'b1;
               if (match) begin
                  bad_run_d = '0;
               end else begin
                  err_d     = 1'b1;
                  count_err = 1'b1;
                  bad_run_d = bad_run_inc;
                  if (bad_run_inc == RUN_W'(UNLOCK_COUNT)) begin
                     state_d    = ACQUIRE;
                     lock_d     = 1'b0;
                     good_run_d = '0;
                     expect_d   = lfsr_next(rx_data);
                  end
               end
            end
         endcase
      end

      if (clear_cnt) begin
         word_cnt_d     = '0;
         err_word_cnt_d = '0;
         err_bit_cnt_d  = '0;
      end else begin
         word_cnt_d     = (count_word && word_cnt != '1) ? word_cnt + 1'b1 : word_cnt;
         err_word_cnt_d = (count_err && err_word_cnt != '1) ? err_word_cnt + 1'b1 : err_word_cnt;
         err_bit_cnt_d  = !count_err ? err_bit_cnt : (bit_sum[24] ? '1 : bit_sum[23:0]);
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so all registers update
   // together from values sampled at the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ACQUIRE;
         expect_word  <= SEED;
         good_run_q   <= '0;
         bad_run_q    <= '0;
         lock         <= 1'b0;
         err          <= 1'b0;
         word_cnt     <= '0;
         err_word_cnt <= '0;
         err_bit_cnt  <= '0;
      end else begin
         state_q      <= state_d;
         expect_word  <= expect_d;
         good_run_q   <= good_run_d;
         bad_run_q    <= bad_run_d;
         lock         <= lock_d;
         err          <= err_d;
         word_cnt     <= word_cnt_d;
         err_word_cnt <= err_word_cnt_d;
         err_bit_cnt  <= err_bit_cnt_d;
      end
   end

endmodule

// File: tb/tb_alct_lfsr_checker.sv
// Directed bench for alct_lfsr_checker: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared one clock later.
module tb_alct_lfsr_checker;

   localparam logic [48:0] TB_SEED = 49'h123456789ABCD;

   typedef struct {
      logic        lock;
      logic        err;
      logic [31:0] words;
      logic [15:0] ew;
      logic [23:0] eb;
      logic [48:0] exp_w;
   } sb_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b0;
   logic        clear_cnt = 1'b0;
   logic [48:0] rx_data = '0;
   logic        lock, err;
   logic [31:0] word_cnt;
   logic [15:0] err_word_cnt;
   logic [23:0] err_bit_cnt;
   logic [48:0] expect_word;

   int  n_cmp = 0;
   int  n_err = 0;
   sb_t sb_q[$];

   logic        m_lock, m_err;
   logic [48:0] m_exp;
   int          m_good, m_bad;
   logic [31:0] m_words;
   logic [15:0] m_ew;
   logic [23:0] m_eb;
   logic [48:0] g;

   always #5 clock = ~clock;

   alct_lfsr_checker dut (
      .clock        (clock),
      .reset        (reset),
      .ce           (ce),
      .rx_data      (rx_data),
      .clear_cnt    (clear_cnt),
      .lock         (lock),
      .err          (err),
      .word_cnt     (word_cnt),
      .err_word_cnt (err_word_cnt),
      .err_bit_cnt  (err_bit_cnt),
      .expect_word  (expect_word)
   );

   function automatic logic [48:0] tb_next(input logic [48:0] x);
      return {x[47:0], ~(x[48] ^ x[39])};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push_expected();
      sb_t e;
      e = '{m_lock, m_err, m_words, m_ew, m_eb, m_exp};
      sb_q.push_back(e);
   endtask

   task automatic compare_popped();
      sb_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL sb_empty: observed 0 entries expected 1");
      end else begin
         e = sb_q.pop_front();
         check("sb_lock",         64'(lock),         64'(e.lock));
         check("sb_err",          64'(err),          64'(e.err));
         check("sb_word_cnt",     64'(word_cnt),     64'(e.words));
         check("sb_err_word_cnt", 64'(err_word_cnt), 64'(e.ew));
         check("sb_err_bit_cnt",  64'(err_bit_cnt),  64'(e.eb));
         check("sb_expect",       64'(expect_word),  64'(e.exp_w));
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; ce = 1'b0; clear_cnt = 1'b0; rx_data = '0;
      m_lock = 1'b0; m_err = 1'b0; m_exp = TB_SEED; m_good = 0; m_bad = 0;
      m_words = '0; m_ew = '0; m_eb = '0;
      push_expected();
      @(posedge clock);
      #1;
      compare_popped();
   endtask

   task automatic step(input logic c, input logic [48:0] d, input logic clr);
      int   nb;
      logic was_locked;
      @(negedge clock);
      reset = 1'b0; ce = c; rx_data = d; clear_cnt = clr;
      was_locked = m_lock;
      m_err = 1'b0;
      nb = 0;
      if (c) begin
         if (!m_lock) begin
            if (d === m_exp) begin
               m_good = m_good + 1;
               m_exp  = tb_next(m_exp);
               if (m_good == 4) begin
                  m_lock = 1'b1;
                  m_bad  = 0;
               end
            end else begin
               m_good = 0;
               m_exp  = tb_next(d);
            end
         end else begin
            nb    = $countones(d ^ m_exp);
            m_exp = tb_next(m_exp);
            if (nb == 0) m_bad = 0;
            else begin
               m_err = 1'b1;
               m_bad = m_bad + 1;
               if (m_bad == 8) begin
                  m_lock = 1'b0;
                  m_good = 0;
                  m_exp  = tb_next(d);
               end
            end
         end
      end
      if (clr) begin
         m_words = '0; m_ew = '0; m_eb = '0;
      end else if (c && was_locked) begin
         if (m_words != 32'hFFFF_FFFF) m_words = m_words + 32'd1;
         if (nb != 0) begin
            if (m_ew != 16'hFFFF) m_ew = m_ew + 16'd1;
            m_eb = (longint'(m_eb) + longint'(nb) > 64'hFF_FFFF) ? 24'hFF_FFFF : m_eb + 24'(nb);
         end
      end
      push_expected();
      @(posedge clock);
      #1;
      compare_popped();
   endtask

   initial begin
      // 1: aligned stream from SEED
      do_reset();
      check("t1_reset_lock", 64'(lock), 64'd0);
      check("t1_reset_expect", 64'(expect_word), 64'(TB_SEED));
      g = TB_SEED;
      for (int i = 1; i <= 100; i++) begin
         step(1'b1, g, 1'b0);
         g = tb_next(g);
         if (i == 3) check("t1_lock_after3", 64'(lock), 64'd0);
         if (i == 4) check("t1_lock_after4", 64'(lock), 64'd1);
         if (i == 5) check("t1_words_after5", 64'(word_cnt), 64'd1);
      end
      check("t1_err_words", 64'(err_word_cnt), 64'd0);
      check("t1_words", 64'(word_cnt), 64'd96);

      // 2: stream starts 37 words into the series
      do_reset();
      g = TB_SEED;
      repeat (37) g = tb_next(g);
      step(1'b1, g, 1'b0);
      g = tb_next(g);
      check("t2_reseed", 64'(expect_word), 64'(g));
      for (int i = 2; i <= 5; i++) begin
         step(1'b1, g, 1'b0);
         g = tb_next(g);
         if (i == 4) check("t2_lock_after4", 64'(lock), 64'd0);
         if (i == 5) check("t2_lock_after5", 64'(lock), 64'd1);
      end
      check("t2_words", 64'(word_cnt), 64'd0);
      check("t2_bits", 64'(err_bit_cnt), 64'd0);

      // 3: three-bit corruption in one word
      step(1'b1, g ^ 49'h1000000100001, 1'b0);
      g = tb_next(g);
      check("t3_err", 64'(err), 64'd1);
      check("t3_err_words", 64'(err_word_cnt), 64'd1);
      check("t3_err_bits", 64'(err_bit_cnt), 64'd3);
      check("t3_lock", 64'(lock), 64'd1);
      step(1'b1, g, 1'b0);
      g = tb_next(g);
      check("t3_clean_err", 64'(err), 64'd0);
      check("t3_clean_err_words", 64'(err_word_cnt), 64'd1);

      // 4: eight fully inverted words drop lock, then re-acquire
      step(1'b1, g, 1'b1);
      g = tb_next(g);
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, ~g, 1'b0);
         g = tb_next(g);
         if (i == 7) check("t4_lock_after7", 64'(lock), 64'd1);
      end
      check("t4_lock_after8", 64'(lock), 64'd0);
      check("t4_err_words", 64'(err_word_cnt), 64'd8);
      check("t4_err_bits", 64'(err_bit_cnt), 64'd392);
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, g, 1'b0);
         g = tb_next(g);
         if (i == 4) check("t4_relock_after4", 64'(lock), 64'd0);
         if (i == 5) check("t4_relock_after5", 64'(lock), 64'd1);
      end
      check("t4_err_words_hold", 64'(err_word_cnt), 64'd8);

      // 5: ce pattern 1,0,0,1
      step(1'b0, '0, 1'b1);
      check("t5_cleared", 64'(word_cnt), 64'd0);
      step(1'b1, g, 1'b0);
      g = tb_next(g);
      step(1'b0, 49'h0DEAD, 1'b0);
      check("t5_hold_expect", 64'(expect_word), 64'(g));
      check("t5_hold_err", 64'(err), 64'd0);
      step(1'b0, ~g, 1'b0);
      step(1'b1, g, 1'b0);
      g = tb_next(g);
      check("t5_words", 64'(word_cnt), 64'd2);
      check("t5_err_words", 64'(err_word_cnt), 64'd0);

      // 6: clear wins over a counted mismatch; bit counter saturation
      step(1'b1, g ^ 49'h1, 1'b1);
      g = tb_next(g);
      check("t6_err", 64'(err), 64'd1);
      check("t6_words", 64'(word_cnt), 64'd0);
      check("t6_err_words", 64'(err_word_cnt), 64'd0);
      check("t6_err_bits", 64'(err_bit_cnt), 64'd0);
      check("t6_lock", 64'(lock), 64'd1);
      force dut.err_bit_cnt = 24'hFFFFF0;
      release dut.err_bit_cnt;
      m_eb = 24'hFFFFF0;
      step(1'b1, ~g, 1'b0);
      g = tb_next(g);
      check("t6_sat", 64'(err_bit_cnt), 64'hFFFFFF);
      step(1'b1, ~g, 1'b0);
      g = tb_next(g);
      check("t6_sat_hold", 64'(err_bit_cnt), 64'hFFFFFF);
      check("t6_sat_lock", 64'(lock), 64'd1);

      @(negedge clock);
      ce = 1'b0;
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
